// File: rtl/lvds_link_pkg.sv
// Shared types and default constants for the LVDS PLL bring-up controller.
package lvds_link_pkg;

  typedef enum logic [2:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StSettle   = 3'd2,
    StAlign    = 3'd3,
    StSlip     = 3'd4,
    StSlipWait = 3'd5,
    StLinked   = 3'd6,
    StFault    = 3'd7
  } link_state_t;

  localparam int unsigned DEF_SER_FACTOR       = 6;
  localparam logic [5:0]  DEF_TRAIN_PATTERN    = 6'b111000;
  localparam int unsigned DEF_PLL_RST_CYCLES   = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT     = 65535;
  localparam int unsigned DEF_SETTLE_CYCLES    = 256;
  localparam int unsigned DEF_MATCH_COUNT      = 16;
  localparam int unsigned DEF_SLIP_WAIT_CYCLES = 4;
  localparam int unsigned DEF_MAX_RETRIES      = 3;

  localparam int unsigned SLIP_CNT_W = 4;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lvds_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module lvds_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lvds_pll_link_ctrl.sv
// LVDS receive PLL bring-up: PLL reset/lock sequencing, bitslip word alignment, link status.
// Define LVDS_LINK_CTRL_RELOCK_EN to recover automatically from lock loss while linked.
module lvds_pll_link_ctrl
  import lvds_link_pkg::*;
#(
  parameter int unsigned             SER_FACTOR       = DEF_SER_FACTOR,
  parameter logic [SER_FACTOR-1:0]   TRAIN_PATTERN    = DEF_TRAIN_PATTERN,
  parameter int unsigned             PLL_RST_CYCLES   = DEF_PLL_RST_CYCLES,
  parameter int unsigned             LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int unsigned             SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
  parameter int unsigned             MATCH_COUNT      = DEF_MATCH_COUNT,
  parameter int unsigned             SLIP_WAIT_CYCLES = DEF_SLIP_WAIT_CYCLES,
  parameter int unsigned             MAX_RETRIES      = DEF_MAX_RETRIES
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_restart,
  input  logic                  i_pll_locked,
  input  logic [SER_FACTOR-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_pll_rst,
  output logic                  o_rx_bitslip,
  output logic                  o_link_ready,
  output logic                  o_fault,
  output logic [2:0]            o_state,
  output logic [SLIP_CNT_W-1:0] o_slip_cnt
);

  localparam int unsigned TMR_MAX = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES,
                                         SLIP_WAIT_CYCLES);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned MATCH_W = $clog2(MATCH_COUNT + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [TMR_W-1:0]      TMR_RST_END    = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]      TMR_LOCK_END   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]      TMR_SETTLE_END = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]      TMR_SWAIT_END  = TMR_W'(SLIP_WAIT_CYCLES - 1);
  localparam logic [MATCH_W-1:0]    MATCH_LAST     = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [RETRY_W-1:0]    RETRY_LIMIT    = RETRY_W'(MAX_RETRIES);
  localparam logic [SLIP_CNT_W-1:0] SLIP_LIMIT     = SLIP_CNT_W'(2 * SER_FACTOR);

  logic w_locked_s;

  lvds_sync_2ff u_lock_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_pll_locked),
    .o_q    (w_locked_s)
  );

  link_state_t           r_state, w_state_d;
  logic [TMR_W-1:0]      r_tmr;
  logic [MATCH_W-1:0]    r_match, w_match_d;
  logic [RETRY_W-1:0]    r_retry, w_retry_d, w_retry_inc;
  logic [SLIP_CNT_W-1:0] r_slip_cnt, w_slip_d;
  logic                  w_retry_fault;
  logic                  w_slip_pulse;
  logic                  r_pll_rst, r_bitslip, r_link, r_fault;

  assign w_retry_inc   = (r_retry == '1) ? r_retry : r_retry + RETRY_W'(1);
  assign w_retry_fault = (w_retry_inc >= RETRY_LIMIT);

  always_comb begin
    w_state_d    = r_state;
    w_match_d    = r_match;
    w_retry_d    = r_retry;
    w_slip_d     = r_slip_cnt;
    w_slip_pulse = 1'b0;

    case (r_state)
      StResetPll: begin
        if (r_tmr == TMR_RST_END) w_state_d = StWaitLock;
      end
      StWaitLock: begin
        if (w_locked_s) begin
          w_state_d = StSettle;
        end else if (r_tmr == TMR_LOCK_END) begin
          w_retry_d = w_retry_inc;
          w_state_d = w_retry_fault ? StFault : StResetPll;
        end
      end
      StSettle: begin
        if (!w_locked_s) begin
          w_state_d = StResetPll;
        end else if (r_tmr == TMR_SETTLE_END) begin
          w_state_d = StAlign;
          w_match_d = '0;
          w_slip_d  = '0;
        end
      end
      StAlign: begin
        if (!w_locked_s) begin
          w_state_d = StResetPll;
        end else if (i_rx_valid) begin
          if (i_rx_data != TRAIN_PATTERN) begin
            w_state_d = StSlip;
          end else if (r_match == MATCH_LAST) begin
            w_state_d = StLinked;
            w_retry_d = '0;
          end else begin
            w_match_d = r_match + MATCH_W'(1);
          end
        end
      end
      StSlip: begin
        // Slip budget of two full word rotations; beyond that the PLL phase is suspect.
        if (!w_locked_s) begin
          w_state_d = StResetPll;
        end else if (r_slip_cnt >= SLIP_LIMIT) begin
          w_retry_d = w_retry_inc;
          w_state_d = w_retry_fault ? StFault : StResetPll;
        end else begin
          w_slip_pulse = 1'b1;
          w_slip_d     = (r_slip_cnt == '1) ? r_slip_cnt : r_slip_cnt + SLIP_CNT_W'(1);
          w_state_d    = StSlipWait;
        end
      end
      StSlipWait: begin
        if (!w_locked_s) begin
          w_state_d = StResetPll;
        end else if (r_tmr == TMR_SWAIT_END) begin
          w_state_d = StAlign;
          w_match_d = '0;
        end
      end
      StLinked: begin
        if (!w_locked_s) begin
`ifdef LVDS_LINK_CTRL_RELOCK_EN
          w_state_d = StResetPll;
          w_retry_d = '0;
`else
          w_state_d = StFault;
`endif
        end
      end
      StFault: begin
        w_state_d = StFault;
      end
      default: begin
        w_state_d = StResetPll;
      end
    endcase

    if (i_restart) begin
      w_state_d    = StResetPll;
      w_match_d    = '0;
      w_retry_d    = '0;
      w_slip_d     = '0;
      w_slip_pulse = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StResetPll;
      r_tmr      <= '0;
      r_match    <= '0;
      r_retry    <= '0;
      r_slip_cnt <= '0;
      r_pll_rst  <= 1'b1;
      r_bitslip  <= 1'b0;
      r_link     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_match    <= w_match_d;
      r_retry    <= w_retry_d;
      r_slip_cnt <= w_slip_d;
      // Timer restarts on every state entry, including a restart into RESET_PLL.
      if (i_restart || (w_state_d != r_state)) begin
        r_tmr <= '0;
      end else if (r_tmr != '1) begin
        r_tmr <= r_tmr + TMR_W'(1);
      end
      r_pll_rst <= (w_state_d == StResetPll);
      r_bitslip <= w_slip_pulse;
      r_link    <= (w_state_d == StLinked);
      r_fault   <= (w_state_d == StFault);
    end
  end

  assign o_pll_rst    = r_pll_rst;
  assign o_rx_bitslip = r_bitslip;
  assign o_link_ready = r_link;
  assign o_fault      = r_fault;
  assign o_state      = r_state;
  assign o_slip_cnt   = r_slip_cnt;

endmodule

// File: doc/lvds_pll_link_ctrl.md
# lvds_pll_link_ctrl

Bring-up controller for the 6x LVDS receive PLL and its deserializer. It sequences PLL reset, watches lock and times out on lock failure. It then aligns deserialized words to a training pattern by issuing bitslip pulses, and asserts `link_ready` only when alignment holds. It sits beside the LVDS PLL and receive deserializer on a free-running system clock, which is not PLL-derived.

## Interface
Parameters:
- `SER_FACTOR`, 6: deserialization factor; width of `rx_data`.
- `TRAIN_PATTERN`, 6'b111000: expected training word.
- `PLL_RST_CYCLES`, 16: `pll_rst` assertion length.
- `LOCK_TIMEOUT`, 65535: cycles allowed in WAIT_LOCK.
- `SETTLE_CYCLES`, 256: post-lock settle time.
- `MATCH_COUNT`, 16: consecutive matching words required to declare alignment.
- `SLIP_WAIT_CYCLES`, 4: cycles after each bitslip before comparison resumes.
- `MAX_RETRIES`, 3: PLL restart attempts before FAULT.

Ports:
- `clk` input 1: free-running system clock; the only clock.
- `rst_n` input 1: asynchronous active-low reset.
- `restart` input 1: single-cycle request to restart the whole sequence.
- `pll_locked` input 1: raw PLL lock, asynchronous to `clk`.
- `rx_data` input SER_FACTOR: deserialized word, already in the `clk` domain.
- `rx_valid` input 1: `rx_data` qualifier.
- `pll_rst` output 1: active-high PLL reset.
- `rx_bitslip` output 1: one-cycle bitslip pulse to the deserializer.
- `link_ready` output 1: link aligned and locked.
- `fault` output 1: sticky failure flag.
- `state_o` output 3: current state code.
- `slip_cnt` output 4: number of bitslips in the current alignment attempt.

## Operation
- `pll_locked` passes through a 2-flop synchronizer, giving `locked_s`. All decisions use `locked_s`.
- State codes: RESET_PLL=0, WAIT_LOCK=1, SETTLE=2, ALIGN=3, SLIP=4, SLIP_WAIT=5, LINKED=6, FAULT=7.
- **RESET_PLL:** `pll_rst`=1 for PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0.
  - `locked_s`=1 → SETTLE.
  - Counter reaches LOCK_TIMEOUT → retry+1 → RESET_PLL.
  - retry reaching MAX_RETRIES → FAULT.
- **SETTLE:** count SETTLE_CYCLES, then go to ALIGN with match count and `slip_cnt` cleared. `locked_s`=0 → RESET_PLL.
- **ALIGN:** evaluate only on cycles with `rx_valid`=1.
  - `rx_data`==TRAIN_PATTERN → match+1.
  - Match reaches MATCH_COUNT → LINKED and retry cleared.
  - Mismatch → SLIP.
- **SLIP:** `rx_bitslip`=1 for exactly one cycle and `slip_cnt`+1, then SLIP_WAIT.
  - If `slip_cnt` would exceed 2*SER_FACTOR, go to RESET_PLL with retry+1 instead of pulsing.
- **SLIP_WAIT:** SLIP_WAIT_CYCLES cycles, then ALIGN with match count cleared.
- **LINKED:** `link_ready`=1. `rx_data` is not monitored. Behaviour on `locked_s`=0 is given under Configuration.
- **FAULT:** `fault`=1. Exit only via `restart`.
- **Priority and lock loss:**
  - `restart` in any state → RESET_PLL with retry, `slip_cnt` and `fault` cleared. It has highest priority.
  - `locked_s`=0 in ALIGN, SLIP or SLIP_WAIT → RESET_PLL, with no retry increment.
- Counters saturate and never wrap.

## Timing
- **Reset values:**
  - `pll_rst`=1
  - `rx_bitslip`=0
  - `link_ready`=0
  - `fault`=0
  - `state_o`=0
  - `slip_cnt`=0
- All outputs are registered.
- `state_o` reflects the state one cycle after the transition decision.
- **`pll_locked` latency:**
  - 2 cycles through the synchronizer.
  - 1 further cycle to the state change.
- `link_ready` falls in the cycle after `locked_s` falls in LINKED.
- Bitslip pulses are separated by at least SLIP_WAIT_CYCLES+1 cycles.
- `pll_rst` width is exactly PLL_RST_CYCLES.

## Configuration
- Macro: `LVDS_LINK_CTRL_RELOCK_EN`.
- **Defined:** lock loss in LINKED goes to RESET_PLL with retry cleared, giving automatic recovery.
- **Undefined:** lock loss in LINKED goes to FAULT. Software must pulse `restart` to recover.

## Structure
- Package `lvds_link_pkg`:
  - state enum `link_state_t` with the fixed codes above.
  - default parameter constants.
  - `SLIP_CNT_W`=4.
- Sub-module `lvds_sync_2ff` for the `pll_locked` synchronizer, with reset value 0.
- Counter widths are derived with $clog2 of their parameters.

## Test plan
1. Release `rst_n`, raise `pll_locked` 100 cycles later.
   - Required: `pll_rst` high for exactly 16 cycles.
   - Required: SETTLE lasts 256 cycles, then ALIGN.
   - Required: 16 words of 6'b111000 → `link_ready`=1 with `slip_cnt`=0.
2. Feed 6'b110001 (pattern rotated by one) and perform one rotation per bitslip.
   - Required: exactly one `rx_bitslip` pulse, then 5 idle cycles.
   - Required: `link_ready` after 16 matches, with `slip_cnt`=1.
3. Hold `pll_locked`=0 (LOCK_TIMEOUT set to 100).
   - Required: three 16-cycle `pll_rst` pulses, then `fault`=1 and `state_o`=7.
   - Required: `restart` → `state_o`=0 and `fault`=0.
4. Drop `pll_locked` while LINKED.
   - With the macro: `link_ready`=0 after 3 cycles, then `pll_rst` pulse.
   - Without the macro: `fault`=1 and no `pll_rst`.
5. Feed constant 6'b000000.
   - Required: 12 slips, then RESET_PLL with retry+1, with no 13th `rx_bitslip`.
6. Assert `restart` in the same cycle as the SLIP state.
   - Required: no `rx_bitslip` pulse; `state_o`=0 on the next cycle.
